sm3_pad_blk_rcv: RTL and testbench



---
 rtl/sm3_pad_blk_rcv.sv | 170 +++++++++++++++++
 tb/tb_sm3_pad_blk_rcv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_pad_blk_rcv.sv
// sm3_pad_blk_rcv: receive side of the SM3 padded-word stream.
// Packs 512/DW padded beats into 512-bit message blocks held in two ping-pong
// buffers, and presents them to the compression core over a valid/ready handshake.
// pad_ena_o tells the padding core that an entire block can be absorbed.
// Optional build macro SM3_RCV_BLK_CNT_EN adds msg_blk_cnt_o. It reports the
// number of blocks in the most recently completed message.
module sm3_pad_blk_rcv #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pad_d_i,
    input  logic          pad_vld_i,
    input  logic          pad_lst_i,
    output logic          pad_ena_o,
    output logic [511:0]  blk_d_o,
    output logic          blk_vld_o,
    output logic          blk_lst_o,
    input  logic          blk_rdy_i,
`ifdef SM3_RCV_BLK_CNT_EN
    output logic [15:0]   msg_blk_cnt_o,
`endif
    output logic          err_ovf_o,
    output logic          err_algn_o
);
    localparam int BPB = 512 / DW;
    localparam int CW  = $clog2(BPB);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BPB - 1);

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_FILL  = 2'd1,
        B_FULL  = 2'd2
    } buf_st_e;

    buf_st_e       st_q  [2];
    buf_st_e       st_d  [2];
    logic [511:0]  dat_q [2];
    logic [511:0]  dat_d [2];
    logic          lst_q [2];
    logic          lst_d [2];
    logic          fptr_q, fptr_d;
    logic          rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          algn_q, algn_d;
    logic          hs_s, wr_s, done_s;
    logic [8:0]    base_s;

    // Next state: drain the read buffer on handshake, then absorb or drop the incoming beat.
    always_comb begin
        st_d   = st_q;
        dat_d  = dat_q;
        lst_d  = lst_q;
        fptr_d = fptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        algn_d = algn_q;
        hs_s   = (st_q[rptr_q] == B_FULL) && blk_rdy_i;
        wr_s   = pad_vld_i && (st_q[fptr_q] != B_FULL);
        done_s = (cnt_q == LAST_BEAT) || pad_lst_i;
        base_s = 9'(cnt_q) * 9'(DW);

        // An emptied buffer is zeroed so that a short final block carries zero padding.
        if (hs_s) begin
            st_d[rptr_q]  = B_EMPTY;
            dat_d[rptr_q] = 512'd0;
            lst_d[rptr_q] = 1'b0;
            rptr_d        = ~rptr_q;
        end else begin
            rptr_d = rptr_q;
        end

        // A beat that arrives while the fill buffer still holds a block is lost.
        if (pad_vld_i && !wr_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        if (wr_s) begin
            dat_d[fptr_q][9'd511 - base_s -: DW] = pad_d_i;
            lst_d[fptr_q] = pad_lst_i;
            if (done_s) begin
                st_d[fptr_q] = B_FULL;
                cnt_d        = '0;
                fptr_d       = ~fptr_q;
            end else begin
                st_d[fptr_q] = B_FILL;
                cnt_d        = cnt_q + CW'(1);
            end
            if (pad_lst_i && (cnt_q != LAST_BEAT)) begin
                algn_d = 1'b1;
            end else begin
                algn_d = algn_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards all buffered data at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]  <= B_EMPTY;
            st_q[1]  <= B_EMPTY;
            dat_q[0] <= 512'd0;
            dat_q[1] <= 512'd0;
            lst_q[0] <= 1'b0;
            lst_q[1] <= 1'b0;
            fptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            algn_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            dat_q  <= dat_d;
            lst_q  <= lst_d;
            fptr_q <= fptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            algn_q <= algn_d;
        end
    end

    assign blk_vld_o  = (st_q[rptr_q] == B_FULL);
    assign blk_d_o    = dat_q[rptr_q];
    assign blk_lst_o  = lst_q[rptr_q];
    assign pad_ena_o  = (cnt_q == '0) && (st_q[fptr_q] == B_EMPTY);
    assign err_ovf_o  = ovf_q;
    assign err_algn_o = algn_q;

`ifdef SM3_RCV_BLK_CNT_EN
    logic [15:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d, bcnt_inc_s;

    // Count blocks of the current message; publish and restart the count on its last block.
    always_comb begin
        bcnt_d     = bcnt_q;
        mcnt_d     = mcnt_q;
        bcnt_inc_s = (bcnt_q == 16'hFFFF) ? bcnt_q : (bcnt_q + 16'd1);
        if (wr_s && done_s) begin
            if (pad_lst_i) begin
                mcnt_d = bcnt_inc_s;
                bcnt_d = 16'd0;
            end else begin
                bcnt_d = bcnt_inc_s;
            end
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Block-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= 16'd0;
            mcnt_q <= 16'd0;
        end else begin
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign msg_blk_cnt_o = mcnt_q;
`endif

endmodule

// File: tb/tb_sm3_pad_blk_rcv.sv
// tb_sm3_pad_blk_rcv: self-checking bench for sm3_pad_blk_rcv.
// The DW=32 instance is compared against a queue-based block model on every
// cycle, using table vectors, directed corner sequences and random traffic.
// The DW=64 instance is checked with a directed two-block message.
module tb_sm3_pad_blk_rcv;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0]  a_d;
    logic         a_vld, a_lst, a_rdy, a_ena, a_bvld, a_blst, a_ovf, a_algn;
    logic [511:0] a_blk;
    logic [63:0]  b_d;
    logic         b_vld, b_lst, b_rdy, b_ena, b_bvld, b_blst, b_ovf, b_algn;
    logic [511:0] b_blk;
`ifdef SM3_RCV_BLK_CNT_EN
    logic [15:0]  a_mcnt, b_mcnt;
`endif

    sm3_pad_blk_rcv #(.DW(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .pad_d_i(a_d), .pad_vld_i(a_vld), .pad_lst_i(a_lst), .pad_ena_o(a_ena),
        .blk_d_o(a_blk), .blk_vld_o(a_bvld), .blk_lst_o(a_blst), .blk_rdy_i(a_rdy),
`ifdef SM3_RCV_BLK_CNT_EN
        .msg_blk_cnt_o(a_mcnt),
`endif
        .err_ovf_o(a_ovf), .err_algn_o(a_algn)
    );

    sm3_pad_blk_rcv #(.DW(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .pad_d_i(b_d), .pad_vld_i(b_vld), .pad_lst_i(b_lst), .pad_ena_o(b_ena),
        .blk_d_o(b_blk), .blk_vld_o(b_bvld), .blk_lst_o(b_blst), .blk_rdy_i(b_rdy),
`ifdef SM3_RCV_BLK_CNT_EN
        .msg_blk_cnt_o(b_mcnt),
`endif
        .err_ovf_o(b_ovf), .err_algn_o(b_algn)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model (DW=32): completed blocks wait in a queue of at most two entries.
    // The block being assembled is held separately. The queue front is the block on offer.
    logic [511:0] m_blk[$];
    bit           m_lst[$];
    logic [511:0] m_part;
    int           m_cnt;
    bit           m_ovf, m_algn;
    logic [15:0]  m_bc, m_mc;

    task automatic m_reset();
        m_blk.delete();
        m_lst.delete();
        m_part = '0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_algn = 1'b0;
        m_bc   = 16'd0;
        m_mc   = 16'd0;
    endtask

    task automatic m_step(input bit vld, input bit lst, input logic [31:0] d, input bit rdy);
        bit hs, drop;
        logic [15:0] inc;
        hs   = rdy && (m_blk.size() > 0);
        drop = vld && (m_cnt == 0) && (m_blk.size() == 2);
        if (hs) begin
            void'(m_blk.pop_front());
            void'(m_lst.pop_front());
        end
        if (vld && drop) begin
            m_ovf = 1'b1;
        end else if (vld) begin
            m_part = m_part | ({480'd0, d} << (32 * (15 - m_cnt)));
            if (lst || (m_cnt == 15)) begin
                if (m_cnt != 15) m_algn = 1'b1;
                m_blk.push_back(m_part);
                m_lst.push_back(lst);
                m_part = '0;
                m_cnt  = 0;
                inc = (m_bc == 16'hFFFF) ? m_bc : (m_bc + 16'd1);
                if (lst) begin
                    m_mc = inc;
                    m_bc = 16'd0;
                end else begin
                    m_bc = inc;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic m_check(input string tag);
        chk({tag, ".vld"}, a_bvld, m_blk.size() > 0);
        chk({tag, ".ena"}, a_ena, (m_cnt == 0) && (m_blk.size() < 2));
        chk({tag, ".ovf"}, a_ovf, m_ovf);
        chk({tag, ".algn"}, a_algn, m_algn);
        if (m_blk.size() > 0) begin
            chk({tag, ".data"}, a_blk, m_blk[0]);
            chk({tag, ".lst"}, a_blst, m_lst[0]);
        end
`ifdef SM3_RCV_BLK_CNT_EN
        chk({tag, ".mcnt"}, a_mcnt, m_mc);
`endif
    endtask

    // One clock on the DW=32 instance: drive, advance the model, compare after the edge.
    task automatic cyc(input bit vld, input bit lst, input logic [31:0] d, input bit rdy, input string tag);
        a_vld = vld;
        a_lst = lst;
        a_d   = d;
        a_rdy = rdy;
        @(posedge clk);
        m_step(vld, lst, d, rdy);
        #1;
        m_check(tag);
    endtask

    typedef struct {
        bit          vld;
        bit          lst;
        bit          rdy;
        logic [31:0] d;
        bit          e_vld;
        bit          e_lst;
        bit          e_ena;
        logic [31:0] e_top;
        logic [31:0] e_bot;
    } vec_t;

    vec_t         tbl [17];
    logic [63:0]  bdat [16];
    logic [511:0] held;
    logic [31:0]  first_w;

    initial begin
        rst_n = 1'b0;
        a_d = 32'd0; a_vld = 1'b0; a_lst = 1'b0; a_rdy = 1'b0;
        b_d = 64'd0; b_vld = 1'b0; b_lst = 1'b0; b_rdy = 1'b0;
        m_reset();

        // Reset values on both widths
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld32", a_bvld, 1'b0);
        chk("rst.lst32", a_blst, 1'b0);
        chk("rst.data32", a_blk, 512'd0);
        chk("rst.ena32", a_ena, 1'b1);
        chk("rst.ovf32", a_ovf, 1'b0);
        chk("rst.algn32", a_algn, 1'b0);
        chk("rst.vld64", b_bvld, 1'b0);
        chk("rst.ena64", b_ena, 1'b1);
        chk("rst.data64", b_blk, 512'd0);
        rst_n = 1'b1;

        // DW=64: a two-block message, blocks appear one cycle after beats 7 and 15
        for (int k = 0; k < 16; k++) bdat[k] = {16'hB00B, 16'(k), 32'h5A5A0000 + 32'(k)};
        b_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b_vld = 1'b1;
            b_lst = (k == 15);
            b_d   = bdat[k];
            @(posedge clk);
            #1;
            if (k == 7 || k == 15) begin
                chk("dw64.vld", b_bvld, 1'b1);
                chk("dw64.lst", b_blst, k == 15);
                chk("dw64.top", b_blk[511:448], (k == 7) ? bdat[0] : bdat[8]);
                chk("dw64.bot", b_blk[63:0], (k == 7) ? bdat[7] : bdat[15]);
                chk("dw64.ena", b_ena, 1'b1);
            end else begin
                chk("dw64.idle", b_bvld, 1'b0);
            end
        end
        b_vld = 1'b0;
        b_lst = 1'b0;
        @(posedge clk);
        #1;
        chk("dw64.drain", b_bvld, 1'b0);
        chk("dw64.ovf", b_ovf, 1'b0);
        chk("dw64.algn", b_algn, 1'b0);

        // Table: the padded "abc" message, one block, compression core always ready
        for (int k = 0; k < 16; k++) begin
            tbl[k].vld   = 1'b1;
            tbl[k].lst   = (k == 15);
            tbl[k].rdy   = 1'b1;
            tbl[k].d     = (k == 0) ? 32'h61626380 : ((k == 15) ? 32'h00000018 : 32'h0);
            tbl[k].e_vld = (k == 15);
            tbl[k].e_lst = (k == 15);
            tbl[k].e_ena = (k == 15);
            tbl[k].e_top = 32'h61626380;
            tbl[k].e_bot = 32'h00000018;
        end
        tbl[16] = '{vld: 1'b0, lst: 1'b0, rdy: 1'b1, d: 32'h0, e_vld: 1'b0, e_lst: 1'b0,
                    e_ena: 1'b1, e_top: 32'h0, e_bot: 32'h0};
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].vld, tbl[i].lst, tbl[i].d, tbl[i].rdy, "abc");
            chk("abc.vld_t", a_bvld, tbl[i].e_vld);
            chk("abc.ena_t", a_ena, tbl[i].e_ena);
            if (tbl[i].e_vld) begin
                chk("abc.lst_t", a_blst, tbl[i].e_lst);
                chk("abc.top_t", a_blk[511:480], tbl[i].e_top);
                chk("abc.bot_t", a_blk[31:0], tbl[i].e_bot);
            end
        end
        chk("abc.ovf", a_ovf, 1'b0);
        chk("abc.algn", a_algn, 1'b0);

        // Backpressure: two blocks with no ready, then an overflowing beat
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, k == 31, $urandom, 1'b0, "bp");
            if (k >= 16) chk("bp.ena_low", a_ena, 1'b0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, "bp.hold");
        held = a_blk;
        cyc(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, "ovf");
        chk("ovf.flag", a_ovf, 1'b1);
        chk("ovf.held", a_blk, held);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, "ovf.sticky");
        chk("ovf.sticky_t", a_ovf, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, "bp.drain1");
        chk("bp.ena_rise", a_ena, 1'b1);
        chk("bp.blk2_vld", a_bvld, 1'b1);
        chk("bp.blk2_lst", a_blst, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, "bp.drain2");

        // Early last on beat 5: short block, zero tail, alignment error
        for (int k = 0; k < 6; k++) cyc(1'b1, k == 5, 32'hA0000000 + 32'(k), 1'b0, "early");
        chk("early.vld", a_bvld, 1'b1);
        chk("early.lst", a_blst, 1'b1);
        chk("early.zero", a_blk[319:0], 320'd0);
        chk("early.algn", a_algn, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, "early.drain");
        first_w = 32'h13572468;
        for (int k = 0; k < 16; k++) cyc(1'b1, k == 15, (k == 0) ? first_w : $urandom, 1'b1, "next");
        chk("next.beat0", a_blk[511:480], first_w);

        // Asynchronous reset in the middle of a fill
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, $urandom, 1'b0, "pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.vld", a_bvld, 1'b0);
        chk("arst.data", a_blk, 512'd0);
        chk("arst.ena", a_ena, 1'b1);
        chk("arst.ovf", a_ovf, 1'b0);
        chk("arst.algn", a_algn, 1'b0);
        m_reset();
        a_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) cyc(1'b1, k == 15, 32'hC0000000 + 32'(k), 1'b0, "post_rst");
        chk("post_rst.top", a_blk[511:480], 32'hC0000000);
        chk("post_rst.bot", a_blk[31:0], 32'hC000000F);
        chk("post_rst.ovf", a_ovf, 1'b0);
        chk("post_rst.algn", a_algn, 1'b0);
`ifdef SM3_RCV_BLK_CNT_EN
        chk("post_rst.mcnt", a_mcnt, 16'd1);
`endif
        cyc(1'b0, 1'b0, 32'h0, 1'b1, "post_rst.drain");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit v, l, r;
            v = (m_cnt > 0) ? ($urandom_range(9) < 8) : ($urandom_range(9) < 6);
            l = v && ($urandom_range(11) == 0);
            r = $urandom_range(1) == 1;
            cyc(v, l, $urandom, r, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
